// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types for the forwarding and hazard controller
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_REG    = 2'b00,
        FWD_MEM_WB = 2'b01,
        FWD_EX_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN,
        LU_STALL,
        MUL_BUSY,
        MUL_LAST
    } hz_state_t;

    localparam int HZ_CNT_W = 8;

endpackage

// File: rtl/forward_select.sv
// rtl/forward_select.sv - single-operand forwarding source compare
import hazard_pkg::*;

module forward_select #(
    parameter int REG_W    = 5,
    parameter int ZERO_REG = 31
) (
    input  logic [REG_W-1:0] src_i,
    input  logic             ex_mem_regwrite_i,
    input  logic [REG_W-1:0] ex_mem_rw_i,
    input  logic             mem_wb_regwrite_i,
    input  logic [REG_W-1:0] mem_wb_rw_i,
    output fwd_sel_t         sel_o
);

    localparam logic [REG_W-1:0] ZERO = REG_W'(ZERO_REG);

    // The younger producer (EX/MEM) holds the newest value, so it wins.
    always_comb begin
        sel_o = FWD_REG;
        if (src_i != ZERO) begin
            if (ex_mem_regwrite_i && (ex_mem_rw_i == src_i)) begin
                sel_o = FWD_EX_MEM;
            end else if (mem_wb_regwrite_i && (mem_wb_rw_i == src_i)) begin
                sel_o = FWD_MEM_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// rtl/hazard_forward_ctrl.sv - operand forwarding, load-use/multiply stall FSM and stall counter
import hazard_pkg::*;

module hazard_forward_ctrl #(
    parameter int REG_W           = 5,
    parameter int NUM_SRC         = 2,
    parameter int ZERO_REG        = 31,
    parameter int LOAD_USE_STALLS = 1,
    parameter int MUL_STALLS      = 2,
    parameter int CNT_W           = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ex_mem_regwrite,
    input  logic [REG_W-1:0]         ex_mem_rw,
    input  logic                     mem_wb_regwrite,
    input  logic [REG_W-1:0]         mem_wb_rw,
    input  logic [NUM_SRC*REG_W-1:0] ex_src,
    input  logic [NUM_SRC*REG_W-1:0] id_src,
    input  logic [NUM_SRC-1:0]       id_src_used,
    input  logic                     id_ex_memread,
    input  logic [REG_W-1:0]         id_ex_rw,
    input  logic                     ex_is_mul,
    input  logic                     flush,
    output logic [NUM_SRC*2-1:0]     forward_sel,
    output logic                     pc_stall,
    output logic                     if_id_stall,
    output logic                     id_ex_bubble,
    output logic                     ex_hold,
    output logic [CNT_W-1:0]         stall_cycles
);

    localparam logic [REG_W-1:0]    ZERO     = REG_W'(ZERO_REG);
    localparam logic [HZ_CNT_W-1:0] MUL_INIT = (MUL_STALLS > 1) ? HZ_CNT_W'(MUL_STALLS - 2) : '0;
    localparam logic [HZ_CNT_W-1:0] LU_INIT  = (LOAD_USE_STALLS > 1) ? HZ_CNT_W'(LOAD_USE_STALLS - 2) : '0;

    hz_state_t             state_q, state_d;
    logic [HZ_CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]      stall_cycles_q, stall_cycles_d;
    logic                  lu_hit;
    logic                  src_match;
    logic                  stall_fetch, bubble, hold;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
        fwd_sel_t sel;
        forward_select #(
            .REG_W   (REG_W),
            .ZERO_REG(ZERO_REG)
        ) u_forward_select (
            .src_i            (ex_src[i*REG_W +: REG_W]),
            .ex_mem_regwrite_i(ex_mem_regwrite),
            .ex_mem_rw_i      (ex_mem_rw),
            .mem_wb_regwrite_i(mem_wb_regwrite),
            .mem_wb_rw_i      (mem_wb_rw),
            .sel_o            (sel)
        );
        assign forward_sel[i*2 +: 2] = reset ? 2'b00 : sel;
    end

    always_comb begin
        src_match = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_src_used[i] && (id_src[i*REG_W +: REG_W] == id_ex_rw)) begin
                src_match = 1'b1;
            end
        end
        lu_hit = id_ex_memread && (id_ex_rw != ZERO) && src_match;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_fetch = 1'b0;
        bubble      = 1'b0;
        hold        = 1'b0;
        case (state_q)
            RUN: begin
                if (ex_is_mul) begin
                    stall_fetch = 1'b1;
                    hold        = 1'b1;
                    cnt_d       = MUL_INIT;
                    state_d     = (MUL_STALLS > 1) ? MUL_BUSY : MUL_LAST;
                end else if (lu_hit) begin
                    stall_fetch = 1'b1;
                    bubble      = 1'b1;
                    cnt_d       = LU_INIT;
                    state_d     = (LOAD_USE_STALLS > 1) ? LU_STALL : RUN;
                end
            end
            LU_STALL: begin
                stall_fetch = 1'b1;
                bubble      = 1'b1;
                if (cnt_q == '0) state_d = RUN;
                else             cnt_d   = cnt_q - HZ_CNT_W'(1);
            end
            MUL_BUSY: begin
                stall_fetch = 1'b1;
                hold        = 1'b1;
                if (cnt_q == '0) state_d = MUL_LAST;
                else             cnt_d   = cnt_q - HZ_CNT_W'(1);
            end
            MUL_LAST: begin
                // The multiply is leaving EX, so ex_is_mul still being high is stale.
                state_d = RUN;
                if (lu_hit) begin
                    stall_fetch = 1'b1;
                    bubble      = 1'b1;
                    cnt_d       = LU_INIT;
                    state_d     = (LOAD_USE_STALLS > 1) ? LU_STALL : RUN;
                end
            end
            default: state_d = RUN;
        endcase
        if (flush) begin
            state_d     = RUN;
            cnt_d       = '0;
            stall_fetch = 1'b0;
            bubble      = 1'b0;
            hold        = 1'b0;
        end
        if (reset) begin
            stall_fetch = 1'b0;
            bubble      = 1'b0;
            hold        = 1'b0;
        end
    end

    assign pc_stall     = stall_fetch;
    assign if_id_stall  = stall_fetch;
    assign id_ex_bubble = bubble;
    assign ex_hold      = hold;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_fetch && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= RUN;
            cnt_q          <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
Combined forwarding and hazard controller for the 5-stage pipeline. It generalises EX/MEM and MEM/WB operand forwarding to NUM_SRC source operands and a parametrised zero register. It adds a sequential stall controller for load-use hazards and for multi-cycle multiplies. It also keeps a saturating stall-cycle performance counter. It sits beside the ID/EX pipeline register and drives the operand muxes, the PC and IF/ID write enables, the ID/EX bubble insert and the EX hold.

Parameters:
REG_W, 5, register address width
NUM_SRC, 2, number of source operands per instruction
ZERO_REG, 31, hardwired-zero register index; never forwarded, never causes a hazard
LOAD_USE_STALLS, 1, bubble cycles per load-use hazard (>=1)
MUL_STALLS, 2, EX hold cycles per multiply (>=1)
CNT_W, 16, perf counter width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
ex_mem_regwrite  in  1  EX/MEM writes a register
ex_mem_rw  in  REG_W  EX/MEM destination
mem_wb_regwrite  in  1  MEM/WB writes a register
mem_wb_rw  in  REG_W  MEM/WB destination
ex_src  in  NUM_SRC*REG_W  ID/EX source registers (operand i at [i*REG_W +: REG_W])
id_src  in  NUM_SRC*REG_W  IF/ID source registers
id_src_used  in  NUM_SRC  IF/ID operand i is actually read
id_ex_memread  in  1  instruction in EX is a load
id_ex_rw  in  REG_W  destination of instruction in EX
ex_is_mul  in  1  instruction in EX is a multi-cycle multiply
flush  in  1  branch taken; kill younger instructions
forward_sel  out  NUM_SRC*2  per-operand mux select
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID
id_ex_bubble  out  1  load NOP into ID/EX
ex_hold  out  1  hold ID/EX and EX stage
stall_cycles  out  CNT_W  saturating count of cycles with pc_stall=1

Behaviour:
- Forwarding is combinational and computed per operand i with src = ex_src[i]:
  - 2'b10 if ex_mem_regwrite, ex_mem_rw==src and src!=ZERO_REG.
  - Otherwise 2'b01 if mem_wb_regwrite, mem_wb_rw==src and src!=ZERO_REG.
  - Otherwise 2'b00.
  - EX/MEM always wins over MEM/WB.
  - forward_sel is all-zero while reset is high.
- lu_hit = id_ex_memread && id_ex_rw!=ZERO_REG && (exists i: id_src_used[i] && id_src[i]==id_ex_rw).
- FSM states: RUN, LU_STALL, MUL_BUSY, MUL_LAST. There is one down-counter cnt, 8 bits wide.
- RUN:
  - If ex_is_mul: assert pc_stall, if_id_stall and ex_hold. Go to MUL_BUSY with cnt=MUL_STALLS-2 if MUL_STALLS>1, else go to MUL_LAST.
  - Else if lu_hit: assert pc_stall, if_id_stall and id_ex_bubble. Go to LU_STALL with cnt=LOAD_USE_STALLS-2 if LOAD_USE_STALLS>1, else stay in RUN.
  - ex_is_mul together with id_ex_memread is a protocol violation; the mul path wins.
- LU_STALL: assert pc_stall, if_id_stall and id_ex_bubble. If cnt==0 go to RUN, else decrement cnt.
- MUL_BUSY: assert pc_stall, if_id_stall and ex_hold. If cnt==0 go to MUL_LAST, else decrement cnt.
- MUL_LAST: no hold, and ex_is_mul is ignored (the multiply is leaving EX). lu_hit is evaluated as in RUN. Next state is RUN, or LU_STALL per the RUN rule.
- Stall totals: a load-use hazard produces exactly LOAD_USE_STALLS bubble cycles; a multiply produces exactly MUL_STALLS hold cycles.
- flush has top priority: all stall outputs are 0 that cycle, the next state is RUN and cnt is cleared. The forwarding outputs are unaffected.
- Outputs pc_stall, if_id_stall, id_ex_bubble and ex_hold are combinational from state plus inputs.
- stall_cycles increments on each clock edge where pc_stall=1 and saturates at all-ones. It is cleared only by reset.
- Reset (asynchronous, any time, including mid-stall): state=RUN, cnt=0, stall_cycles=0. All stall outputs are 0 while reset is high.

Decomposition:
- Package hazard_pkg:
  - fwd_sel_t enum: FWD_REG=2'b00, FWD_MEM_WB=2'b01, FWD_EX_MEM=2'b10.
  - hz_state_t enum: RUN, LU_STALL, MUL_BUSY, MUL_LAST.
- Sub-module forward_select: one-operand forwarding compare, instantiated NUM_SRC times with a generate loop.

Test Plan:
1. ex_mem_regwrite=1, ex_mem_rw=3, mem_wb_regwrite=1, mem_wb_rw=3, ex_src[0]=3, ex_src[1]=4 -> forward_sel[0]=10, forward_sel[1]=00. Then set ex_mem_rw=7 -> forward_sel[0]=01.
2. ex_mem_rw=31 with ex_src[0]=31 and both regwrites asserted -> forward_sel[0]=00; no stall when id_ex_rw=31 with id_ex_memread=1.
3. Load-use: id_ex_memread=1, id_ex_rw=5, id_src[1]=5, id_src_used=2'b10 -> 1 cycle of pc_stall, if_id_stall and id_ex_bubble. With LOAD_USE_STALLS=3 -> 3 consecutive cycles. With id_src_used=2'b00 -> no stall.
4. MUL_STALLS=3, ex_is_mul held high -> ex_hold high for exactly 3 cycles, 1 MUL_LAST cycle with no hold, then RUN. stall_cycles advances by 3.
5. flush asserted in the 2nd MUL_BUSY cycle -> stall outputs drop that cycle and the FSM is in RUN next cycle. Reset asserted mid-LU_STALL -> outputs 0 immediately, stall_cycles=0.
6. CNT_W=4: force 20 stall cycles -> stall_cycles saturates at 15.
